rx_lock_ctrl: RTL and testbench

Symbol-lock controller for the USB receive PCS. It sits after the 10b/8b decoder in the PCLK domain and watches the decoded symbol stream for K28.5 commas and decode errors. It sequences the comma aligner by asserting `Align_En` until lock is acquired. It then declares and maintains `Symbol_Lock` using an error-level / good-run hysteresis, and reports per-symbol PIPE-style receive status.

---
 rtl/pcs_rx_pkg.sv | 25 ++
 rtl/rx_sym_qualifier.sv | 32 +++
 rtl/rx_lock_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rx_lock_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_rx_pkg.sv
// Shared definitions for the USB receive PCS: lock-FSM state encoding,
// the K28.5 comma byte and the PIPE RxStatus codes.
package pcs_rx_pkg;

  // Lock FSM state encoding
  typedef logic [1:0] lock_state_t;
  localparam lock_state_t ST_LOS      = 2'd0;
  localparam lock_state_t ST_ACQ      = 2'd1;
  localparam lock_state_t ST_LOCKED   = 2'd2;
  localparam lock_state_t ST_DEGRADED = 2'd3;

  // Decoded K28.5 comma byte
  localparam logic [7:0] K28_5_BYTE = 8'hBC;

  // PIPE-style receive status codes
  localparam logic [2:0] RX_STATUS_OK       = 3'b000;
  localparam logic [2:0] RX_STATUS_DEC_ERR  = 3'b100;
  localparam logic [2:0] RX_STATUS_DISP_ERR = 3'b111;

  // True in the states where Symbol_Lock is asserted
  function automatic logic is_locked_state(input lock_state_t s);
    return (s == ST_LOCKED) || (s == ST_DEGRADED);
  endfunction

endpackage

// File: rtl/rx_sym_qualifier.sv
// Combinational symbol classifier: splits each valid decoded symbol into
// bad / comma / good and encodes the per-symbol receive status.
module rx_sym_qualifier
  import pcs_rx_pkg::*;
(
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_k,
  input  logic       sym_code_err,
  input  logic       sym_disp_err,
  output logic       is_bad,
  output logic       is_comma,
  output logic       is_good,
  output logic [2:0] status
);

  // Classification; every class is gated by sym_valid so idle cycles are inert
  always_comb begin
    is_bad   = sym_valid && (sym_code_err || sym_disp_err);
    is_comma = sym_valid && !is_bad && sym_k && (sym_data == K28_5_BYTE);
    is_good  = sym_valid && !is_bad && !is_comma;
  end

  // Status encode: a code violation outranks a disparity error
  always_comb begin
    if (!sym_valid)        status = RX_STATUS_OK;
    else if (sym_code_err) status = RX_STATUS_DEC_ERR;
    else if (sym_disp_err) status = RX_STATUS_DISP_ERR;
    else                   status = RX_STATUS_OK;
  end

endmodule

// File: rtl/rx_lock_ctrl.sv
// Symbol-lock controller for the USB receive PCS (PCLK domain).
// Drives the comma aligner until lock, then holds Symbol_Lock with an
// error-level / good-run hysteresis. All outputs are registered.
// Optional feature macro: RX_LOCK_ERR_CNT_EN builds the saturating
// Err_Count register and Err_Clr; without it Err_Count is tied to 0.
module rx_lock_ctrl
  import pcs_rx_pkg::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int GOOD_RUN    = 4,
  parameter int MAX_ERRS    = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 PCLK,
  input  logic                 RST,
  input  logic                 Lock_En,
  input  logic                 Elec_Idle,
  input  logic                 Sym_Valid,
  input  logic [7:0]           Sym_Data,
  input  logic                 Sym_K,
  input  logic                 Sym_Code_Err,
  input  logic                 Sym_Disp_Err,
  input  logic                 Err_Clr,
  output logic                 Align_En,
  output logic                 Symbol_Lock,
  output logic                 Lock_Lost,
  output logic [2:0]           RX_Status,
  output logic [ERR_CNT_W-1:0] Err_Count
);

  localparam int CCW = $clog2(LOCK_COMMAS + 1);
  localparam int ELW = $clog2(MAX_ERRS + 1);
  localparam int GRW = $clog2(GOOD_RUN + 1);

  localparam logic [CCW-1:0] COMMA_LAST = CCW'(LOCK_COMMAS - 1);
  localparam logic [ELW-1:0] LVL_LAST   = ELW'(MAX_ERRS - 1);
  localparam logic [GRW-1:0] RUN_LAST   = GRW'(GOOD_RUN - 1);

  logic        is_bad, is_comma, is_good;
  logic [2:0]  sym_status;

  lock_state_t    state, state_n;
  logic [CCW-1:0] comma_cnt, comma_cnt_n;
  logic [ELW-1:0] err_lvl, err_lvl_n;
  logic [GRW-1:0] good_run, good_run_n;

  rx_sym_qualifier u_qual (
    .sym_valid    (Sym_Valid),
    .sym_data     (Sym_Data),
    .sym_k        (Sym_K),
    .sym_code_err (Sym_Code_Err),
    .sym_disp_err (Sym_Disp_Err),
    .is_bad       (is_bad),
    .is_comma     (is_comma),
    .is_good      (is_good),
    .status       (sym_status)
  );

  // Next-state and counter update for the lock FSM
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_n     = state;
    comma_cnt_n = comma_cnt;
    err_lvl_n   = err_lvl;
    good_run_n  = good_run;
    if (!Lock_En || Elec_Idle) begin
      // Forced LOS wins over whatever symbol arrives in the same cycle
      state_n     = ST_LOS;
      comma_cnt_n = '0;
      err_lvl_n   = '0;
      good_run_n  = '0;
    end else if (Sym_Valid) begin
      case (state)
        ST_LOS: begin
          if (is_comma) begin
            if (LOCK_COMMAS == 1) begin
              state_n = ST_LOCKED;
            end else begin
              state_n     = ST_ACQ;
              comma_cnt_n = CCW'(1);
            end
          end
        end
        ST_ACQ: begin
          if (is_bad) begin
            state_n     = ST_LOS;
            comma_cnt_n = '0;
          end else if (is_comma) begin
            if (comma_cnt == COMMA_LAST) begin
              state_n     = ST_LOCKED;
              comma_cnt_n = '0;
            end else begin
              comma_cnt_n = comma_cnt + CCW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (is_bad) begin
            // A single-error budget loses lock on the first bad symbol
            if (MAX_ERRS == 1) begin
              state_n = ST_LOS;
            end else begin
              state_n    = ST_DEGRADED;
              err_lvl_n  = ELW'(1);
              good_run_n = '0;
            end
          end
        end
        ST_DEGRADED: begin
          if (is_bad) begin
            good_run_n = '0;
            if (err_lvl == LVL_LAST) begin
              state_n   = ST_LOS;
              err_lvl_n = '0;
            end else begin
              err_lvl_n = err_lvl + ELW'(1);
            end
          end else if (is_good || is_comma) begin
            if (good_run == RUN_LAST) begin
              good_run_n = '0;
              err_lvl_n  = err_lvl - ELW'(1);
              if (err_lvl == ELW'(1)) state_n = ST_LOCKED;
            end else begin
              good_run_n = good_run + GRW'(1);
            end
          end
        end
        default: state_n = ST_LOS;
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state       <= ST_LOS;
      comma_cnt   <= '0;
      err_lvl     <= '0;
      good_run    <= '0;
      Align_En    <= 1'b1;
      Symbol_Lock <= 1'b0;
      Lock_Lost   <= 1'b0;
      RX_Status   <= RX_STATUS_OK;
    end else begin
      state       <= state_n;
      comma_cnt   <= comma_cnt_n;
      err_lvl     <= err_lvl_n;
      good_run    <= good_run_n;
      Align_En    <= !is_locked_state(state_n);
      Symbol_Lock <= is_locked_state(state_n);
      Lock_Lost   <= (state_n == ST_LOS) && is_locked_state(state);
      RX_Status   <= sym_status;
    end
  end

`ifdef RX_LOCK_ERR_CNT_EN
  logic                 bad_counted;
  logic [ERR_CNT_W-1:0] err_count_q;

  // Only bad symbols seen while locked count, even if LOS is forced that cycle
  assign bad_counted = is_bad && is_locked_state(state);

  // Saturating error counter; a clear coinciding with a counted error leaves 1
  always_ff @(posedge PCLK) begin
    if (RST) begin
      err_count_q <= '0;
    end else if (Err_Clr) begin
      err_count_q <= bad_counted ? ERR_CNT_W'(1) : '0;
    end else if (bad_counted && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign Err_Count = err_count_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = Err_Clr;
  assign Err_Count      = '0;
`endif

endmodule

// File: tb/tb_rx_lock_ctrl.sv
// Scoreboard bench for rx_lock_ctrl: the driver pushes the hand-computed
// expected outputs for each cycle it drives; a negedge monitor pops and
// compares them against the registered outputs.
module tb_rx_lock_ctrl;

  localparam int CW = 8;

  logic          PCLK = 1'b0;
  logic          RST, Lock_En, Elec_Idle, Sym_Valid, Sym_K;
  logic          Sym_Code_Err, Sym_Disp_Err, Err_Clr;
  logic [7:0]    Sym_Data;
  logic          Align_En, Symbol_Lock, Lock_Lost;
  logic [2:0]    RX_Status;
  logic [CW-1:0] Err_Count;

  localparam logic [2:0] OK   = 3'b000;
  localparam logic [2:0] DEC  = 3'b100;
  localparam logic [2:0] DISP = 3'b111;

  typedef enum {S_NONE, S_INV_BAD, S_COMMA, S_GOOD, S_KGOOD, S_CODE, S_DISP, S_BOTH} kind_t;

  typedef struct {
    logic       lock;
    logic       align;
    logic       lost;
    logic [2:0] stat;
    int         err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rx_lock_ctrl #(
    .LOCK_COMMAS (3),
    .GOOD_RUN    (4),
    .MAX_ERRS    (4),
    .ERR_CNT_W   (CW)
  ) dut (
    .PCLK         (PCLK),
    .RST          (RST),
    .Lock_En      (Lock_En),
    .Elec_Idle    (Elec_Idle),
    .Sym_Valid    (Sym_Valid),
    .Sym_Data     (Sym_Data),
    .Sym_K        (Sym_K),
    .Sym_Code_Err (Sym_Code_Err),
    .Sym_Disp_Err (Sym_Disp_Err),
    .Err_Clr      (Err_Clr),
    .Align_En     (Align_En),
    .Symbol_Lock  (Symbol_Lock),
    .Lock_Lost    (Lock_Lost),
    .RX_Status    (RX_Status),
    .Err_Count    (Err_Count)
  );

  always #5 PCLK = ~PCLK;

  // The error counter only exists when the feature macro is defined
  function automatic int err_exp(input int e);
`ifdef RX_LOCK_ERR_CNT_EN
    return e;
`else
    return 0;
`endif
  endfunction

  // Drive one symbol for one cycle; queue what the outputs must show after the edge
  task automatic step(input kind_t kind, input logic lock, input logic align,
                      input logic lost, input logic [2:0] stat, input int err,
                      input string name);
    exp_t e;
    Sym_Valid    = !(kind inside {S_NONE, S_INV_BAD});
    Sym_K        = kind inside {S_COMMA, S_KGOOD};
    Sym_Data     = (kind == S_KGOOD) ? 8'h1C : 8'hBC;
    Sym_Code_Err = kind inside {S_INV_BAD, S_CODE, S_BOTH};
    Sym_Disp_Err = kind inside {S_DISP, S_BOTH};
    @(posedge PCLK);
    e.lock  = lock;
    e.align = align;
    e.lost  = lost;
    e.stat  = stat;
    e.err   = err_exp(err);
    e.name  = name;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got lock=%b align=%b lost=%b stat=%b err=%0d, want lock=%b align=%b lost=%b stat=%b err=%0d",
               name, got[13], got[12], got[11], got[10:8], got[7:0],
               want[13], want[12], want[11], want[10:8], want[7:0]);
    end
  endtask

  // Monitor: outputs are stable at the falling edge
  always @(negedge PCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, {Symbol_Lock, Align_En, Lock_Lost, RX_Status, Err_Count},
            {e.lock, e.align, e.lost, e.stat, CW'(e.err)});
    end
  end

  task automatic acquire(input int err, input string name);
    step(S_COMMA, 0, 1, 0, OK, err, {name, "_c1"});
    step(S_COMMA, 0, 1, 0, OK, err, {name, "_c2"});
    step(S_COMMA, 1, 0, 0, OK, err, {name, "_c3_lock"});
  endtask

  initial begin
    RST = 1'b1; Lock_En = 1'b1; Elec_Idle = 1'b0; Err_Clr = 1'b0;
    Sym_Valid = 1'b0; Sym_K = 1'b0; Sym_Data = 8'h00;
    Sym_Code_Err = 1'b0; Sym_Disp_Err = 1'b0;
    #2;
    step(S_NONE, 0, 1, 0, OK, 0, "reset_0");
    step(S_COMMA, 0, 1, 0, OK, 0, "reset_1");
    RST = 1'b0;

    // Three back-to-back commas acquire lock
    acquire(0, "acq");

    // Lock_En low forces LOS with a single Lock_Lost pulse
    Lock_En = 1'b0;
    step(S_NONE, 0, 1, 1, OK, 0, "lock_en_off_lost");
    Lock_En = 1'b1;
    step(S_NONE, 0, 1, 0, OK, 0, "lost_one_cycle");

    // Two commas then a code error: back to LOS, no Lock_Lost, fresh count needed
    step(S_COMMA, 0, 1, 0, OK, 0, "acq2_c1");
    step(S_COMMA, 0, 1, 0, OK, 0, "acq2_c2");
    step(S_CODE,  0, 1, 0, DEC, 0, "acq2_code_err");
    step(S_NONE,  0, 1, 0, OK, 0, "status_clears");
    step(S_COMMA, 0, 1, 0, OK, 0, "acq3_c1");
    step(S_COMMA, 0, 1, 0, OK, 0, "acq3_c2");
    step(S_GOOD,  0, 1, 0, OK, 0, "acq3_bc_not_k");
    step(S_KGOOD, 0, 1, 0, OK, 0, "acq3_k_not_bc");
    step(S_COMMA, 1, 0, 0, OK, 0, "acq3_c3_lock");

    // Invalid cycle with error flags is ignored; then 1 bad + 4 good recovers
    step(S_INV_BAD, 1, 0, 0, OK, 0, "invalid_ignored");
    step(S_DISP, 1, 0, 0, DISP, 1, "deg_disp");
    for (int i = 0; i < 4; i++) step(S_GOOD, 1, 0, 0, OK, 1, "deg_recover");

    // Four bad symbols, three good between each: err_lvl reaches MAX_ERRS
    step(S_CODE, 1, 0, 0, DEC, 2, "lvl1");
    for (int i = 0; i < 3; i++) step(S_GOOD, 1, 0, 0, OK, 2, "lvl1_good");
    step(S_BOTH, 1, 0, 0, DEC, 3, "lvl2_code_over_disp");
    for (int i = 0; i < 3; i++) step(S_GOOD, 1, 0, 0, OK, 3, "lvl2_good");
    step(S_DISP, 1, 0, 0, DISP, 4, "lvl3");
    for (int i = 0; i < 3; i++) step(S_COMMA, 1, 0, 0, OK, 4, "lvl3_comma");
    step(S_CODE, 0, 1, 1, DEC, 5, "lvl4_lost");
    step(S_NONE, 0, 1, 0, OK, 5, "lvl4_after");

    // Elec_Idle with a bad symbol while locked: LOS, pulse, error still counted
    acquire(5, "idle");
    Elec_Idle = 1'b1;
    step(S_CODE,  0, 1, 1, DEC, 6, "idle_bad_lost");
    step(S_NONE,  0, 1, 0, OK, 6, "idle_hold");
    step(S_COMMA, 0, 1, 0, OK, 6, "idle_comma_ignored");
    Elec_Idle = 1'b0;
    acquire(6, "post_idle");

    // Reset mid-operation: reset values, no Lock_Lost pulse
    RST = 1'b1;
    step(S_COMMA, 0, 1, 0, OK, 0, "mid_reset");
    RST = 1'b0;

    // Drive the counter into saturation while staying locked
    acquire(0, "sat");
    for (int i = 1; i <= 260; i++) begin
      int e;
      e = (i > 255) ? 255 : i;
      step(S_DISP, 1, 0, 0, DISP, e, "sat_bad");
      for (int j = 0; j < 4; j++) step(S_GOOD, 1, 0, 0, OK, e, "sat_good");
    end

    // Clear with a concurrent counted error gives 1; clear alone gives 0
    Err_Clr = 1'b1;
    step(S_DISP, 1, 0, 0, DISP, 1, "clr_with_bad");
    Err_Clr = 1'b0;
    Err_Clr = 1'b1;
    step(S_GOOD, 1, 0, 0, OK, 0, "clr_alone");
    Err_Clr = 1'b0;
    for (int i = 0; i < 3; i++) step(S_GOOD, 1, 0, 0, OK, 0, "clr_recover");
    step(S_NONE, 1, 0, 0, OK, 0, "final_locked");

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge PCLK);
    @(negedge PCLK);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
